// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: decode->execute register slice with a 2-entry skid buffer and synchronous flush.
// Define ID_EX_PERF_EN to add the back-pressure and squash performance counters.
module id_ex_pipe_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 4,
  parameter int DCCTRL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data1,
  input  logic [DATA_W-1:0]   in_data2,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic [ALUOP_W-1:0]  in_aluop,
  input  logic                in_we,
  input  logic [DCCTRL_W-1:0] in_dcctrl,
  input  logic [REG_AW-1:0]   in_wb_addr,
  input  logic [REG_AW-1:0]   in_s1_addr,
  input  logic [REG_AW-1:0]   in_s2_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data1,
  output logic [DATA_W-1:0]   out_data2,
  output logic [DATA_W-1:0]   out_imm,
  output logic [ALUOP_W-1:0]  out_aluop,
  output logic                out_we,
  output logic [DCCTRL_W-1:0] out_dcctrl,
  output logic [REG_AW-1:0]   out_wb_addr,
  output logic [REG_AW-1:0]   out_s1_addr,
  output logic [REG_AW-1:0]   out_s2_addr
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  // state | meaning
  // EMPTY | no valid entry, EX slot is a bubble
  // ONE   | main register holds the EX slot, skid empty
  // FULL  | main and skid both valid, decoder stalled
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam int PW = 3*DATA_W + ALUOP_W + 1 + DCCTRL_W + 3*REG_AW;

  state_t              state, state_nx;
  logic [PW-1:0]       in_pl, main_pl, skid_pl;
  logic                xin, xout;
  logic                load_main_in, load_main_skid, load_skid;
  logic                main_we;
  logic [DCCTRL_W-1:0] main_dcctrl;

  assign in_pl = {in_data1, in_data2, in_imm, in_aluop, in_we, in_dcctrl,
                  in_wb_addr, in_s1_addr, in_s2_addr};
  assign {out_data1, out_data2, out_imm, out_aluop, main_we, main_dcctrl,
          out_wb_addr, out_s1_addr, out_s2_addr} = main_pl;

  assign xin  = in_valid & in_ready;
  assign xout = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: if (xin) begin
          state_nx     = ONE;
          load_main_in = 1'b1;
        end
        ONE: begin
          if (xin && xout) begin
            load_main_in = 1'b1;
          end else if (xin) begin
            state_nx  = FULL;
            load_skid = 1'b1;
          end else if (xout) begin
            state_nx = EMPTY;
          end
        end
        FULL: if (xout) begin
          state_nx       = ONE;
          load_main_skid = 1'b1;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // in_ready decodes only the state register, so there is no out_ready->in_ready path
  always_comb begin
    out_valid  = (state != EMPTY);
    in_ready   = (state != FULL);
    out_we     = out_valid & main_we;
    out_dcctrl = out_valid ? main_dcctrl : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_pl <= '0;
      skid_pl <= '0;
    end else begin
      if (load_main_in)        main_pl <= in_pl;
      else if (load_main_skid) main_pl <= skid_pl;
      if (load_skid)           skid_pl <= in_pl;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] held_cnt;

  assign held_cnt = (state == FULL) ? 32'd2 : (state == ONE) ? 32'd1 : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush)                   perf_flush_cnt <= perf_flush_cnt + held_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: directed scenarios plus random traffic against a 2-deep queue model.
// Perf counter checks are compiled in when ID_EX_PERF_EN is defined.
module tb_id_ex_pipe_stage;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic        we;
    logic [2:0]  dc;
    logic [4:0]  wb;
    logic [4:0]  s1;
    logic [4:0]  s2;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data1, in_data2, in_imm, out_data1, out_data2, out_imm;
  logic [3:0]  in_aluop, out_aluop;
  logic        in_we, out_we;
  logic [2:0]  in_dcctrl, out_dcctrl;
  logic [4:0]  in_wb_addr, in_s1_addr, in_s2_addr, out_wb_addr, out_s1_addr, out_s2_addr;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  pl_t         q[$];
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm),
    .in_aluop(in_aluop), .in_we(in_we), .in_dcctrl(in_dcctrl),
    .in_wb_addr(in_wb_addr), .in_s1_addr(in_s1_addr), .in_s2_addr(in_s2_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm),
    .out_aluop(out_aluop), .out_we(out_we), .out_dcctrl(out_dcctrl),
    .out_wb_addr(out_wb_addr), .out_s1_addr(out_s1_addr), .out_s2_addr(out_s2_addr)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  function automatic pl_t rand_pl();
    pl_t p;
    p.d1 = $urandom; p.d2 = $urandom; p.imm = $urandom;
    p.aluop = 4'($urandom); p.we = 1'($urandom); p.dc = 3'($urandom);
    p.wb = 5'($urandom); p.s1 = 5'($urandom); p.s2 = 5'($urandom);
    return p;
  endfunction

  // One clock of stimulus: drive at the negedge, advance the queue model, compare at the next negedge.
  task automatic drive_cycle(input logic v, input logic ordy, input logic fl, input pl_t p);
    logic m_rdy;
    pl_t  obs;
    in_valid = v; out_ready = ordy; flush = fl;
    {in_data1, in_data2, in_imm, in_aluop, in_we, in_dcctrl,
     in_wb_addr, in_s1_addr, in_s2_addr} = p;
    m_rdy = (q.size() < 2);
    if (q.size() > 0 && !ordy) m_stall = m_stall + 1;
    if (fl) begin
      m_flush = m_flush + 32'(q.size());
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && m_rdy) q.push_back(p);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== (q.size() > 0)) begin
      n_errors++; $display("FAIL out_valid: got %b want %b", out_valid, q.size() > 0);
    end
    n_checks++;
    if (in_ready !== (q.size() < 2)) begin
      n_errors++; $display("FAIL in_ready: got %b want %b", in_ready, q.size() < 2);
    end
    obs = {out_data1, out_data2, out_imm, out_aluop, out_we, out_dcctrl,
           out_wb_addr, out_s1_addr, out_s2_addr};
    n_checks++;
    if (q.size() > 0) begin
      if (obs !== q[0]) begin
        n_errors++; $display("FAIL payload: got %h want %h", obs, q[0]);
      end
    end else if (out_we !== 1'b0 || out_dcctrl !== 3'd0) begin
      n_errors++; $display("FAIL bubble_ctrl: got we=%b dc=%h want 0/0", out_we, out_dcctrl);
    end
`ifdef ID_EX_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== m_stall || perf_flush_cnt !== m_flush) begin
      n_errors++;
      $display("FAIL perf: got stall=%0d flush=%0d want %0d/%0d",
               perf_stall_cnt, perf_flush_cnt, m_stall, m_flush);
    end
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, rand_pl());
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {in_data1, in_data2, in_imm, in_aluop, in_we, in_dcctrl,
     in_wb_addr, in_s1_addr, in_s2_addr} = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_hs: got v=%b r=%b want 0/1", out_valid, in_ready);
    end
    n_checks++;
    if ({out_data1, out_data2, out_imm, out_aluop, out_we, out_dcctrl,
         out_wb_addr, out_s1_addr, out_s2_addr} !== '0) begin
      n_errors++; $display("FAIL reset_payload: got %h want 0", out_data1);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    pl_t p;
    for (int k = 1; k <= 5; k++) begin
      p = rand_pl(); p.d1 = 32'(k);
      drive_cycle(1'b1, 1'b1, 1'b0, p);
      n_checks++;
      if (out_valid !== 1'b1 || out_data1 !== 32'(k)) begin
        n_errors++; $display("FAIL stream: got v=%b d1=%0d want 1/%0d", out_valid, out_data1, k);
      end
    end
    drain();
  endtask

  task automatic test_back_pressure();
    pl_t a, b;
    a = rand_pl(); b = rand_pl();
    drive_cycle(1'b1, 1'b0, 1'b0, a);
    drive_cycle(1'b1, 1'b0, 1'b0, b);
    n_checks++;
    if (in_ready !== 1'b0 || out_data1 !== a.d1) begin
      n_errors++; $display("FAIL bp_full: got r=%b d1=%h want 0/%h", in_ready, out_data1, a.d1);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, rand_pl());
    drive_cycle(1'b0, 1'b1, 1'b0, rand_pl());
    n_checks++;
    if (out_data1 !== b.d1 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_release: got r=%b d1=%h want 1/%h", in_ready, out_data1, b.d1);
    end
    drive_cycle(1'b0, 1'b1, 1'b0, rand_pl());
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL bp_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush_full();
    pl_t a, b;
    logic [31:0] base;
    a = rand_pl(); a.we = 1'b1; a.dc = 3'b101;
    b = rand_pl(); b.we = 1'b1; b.dc = 3'b011;
    drive_cycle(1'b1, 1'b0, 1'b0, a);
    drive_cycle(1'b1, 1'b0, 1'b0, b);
    base = m_flush;
    drive_cycle(1'b1, 1'b0, 1'b1, rand_pl());
    n_checks++;
    if (out_valid !== 1'b0 || out_we !== 1'b0 || out_dcctrl !== 3'd0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_full: got v=%b we=%b dc=%h r=%b want 0/0/0/1",
               out_valid, out_we, out_dcctrl, in_ready);
    end
`ifdef ID_EX_PERF_EN
    n_checks++;
    if (perf_flush_cnt !== base + 32'd2) begin
      n_errors++; $display("FAIL flush_cnt: got %0d want %0d", perf_flush_cnt, base + 32'd2);
    end
`endif
  endtask

  task automatic test_flush_xin();
    drive_cycle(1'b1, 1'b1, 1'b1, rand_pl());
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_xin_empty: got v=%b want 0", out_valid);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, rand_pl());
    drive_cycle(1'b1, 1'b1, 1'b1, rand_pl());
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_xin_one: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    pl_t p;
    drive_cycle(1'b1, 1'b0, 1'b0, rand_pl());
    drive_cycle(1'b1, 1'b0, 1'b0, rand_pl());
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data1 !== 32'd0 || out_we !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got v=%b r=%b d1=%h we=%b want 0/1/0/0",
               out_valid, in_ready, out_data1, out_we);
    end
`ifdef ID_EX_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      n_errors++; $display("FAIL async_reset_perf: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    #1 rst = 1'b0;
    q.delete(); m_stall = 0; m_flush = 0;
    @(negedge clk);
    p = rand_pl();
    drive_cycle(1'b1, 1'b1, 1'b0, p);
    n_checks++;
    if (out_valid !== 1'b1 || out_data1 !== p.d1) begin
      n_errors++; $display("FAIL post_reset: got v=%b d1=%h want 1/%h", out_valid, out_data1, p.d1);
    end
    drain();
  endtask

  task automatic test_perf_stall();
`ifdef ID_EX_PERF_EN
    logic [31:0] base;
    drive_cycle(1'b1, 1'b1, 1'b0, rand_pl());
    base = m_stall;
    for (int i = 0; i < 7; i++) drive_cycle(1'b0, 1'b0, 1'b0, rand_pl());
    n_checks++;
    if (perf_stall_cnt !== base + 32'd7) begin
      n_errors++; $display("FAIL stall_cnt: got %0d want %0d", perf_stall_cnt, base + 32'd7);
    end
    drain();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      drive_cycle(1'(($urandom % 4) != 0), 1'(($urandom % 3) != 0),
                  1'(($urandom % 20) == 0), rand_pl());
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush_full();
    test_flush_xin();
    test_async_reset();
    test_perf_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
